// File: rtl/iob_sync_asym_fifo_w_big_pkg.sv
// Shared width helpers and parameter legality checks for the wide-write /
// narrow-read synchronous FIFO and its storage.
package iob_sync_asym_fifo_w_big_pkg;

  function automatic int max_i(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  function automatic int min_i(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  function automatic int log2_ceil(input int v);
    return $clog2(v);
  endfunction

  function automatic bit is_pow2(input int v);
    return (v > 0) && ((v & (v - 1)) == 0);
  endfunction

  function automatic int calc_ratio(input int w_data_w, input int r_data_w);
    return w_data_w / max_i(r_data_w, 1);
  endfunction

  function automatic int calc_w_addr_w(input int r_addr_w, input int ratio);
    return r_addr_w - log2_ceil(ratio);
  endfunction

  // Write width must be an exact power-of-two multiple (>=2) of read width,
  // and at least one wide slot must exist.
  function automatic bit params_ok(input int w_data_w, input int r_data_w,
                                   input int r_addr_w);
    int ratio;
    ratio = calc_ratio(w_data_w, r_data_w);
    return (r_data_w > 0) && (w_data_w == ratio * r_data_w) &&
           (min_i(ratio, 2) == 2) && is_pow2(ratio) &&
           (r_addr_w > log2_ceil(ratio));
  endfunction

endpackage

// File: rtl/iob_2p_assim_mem_w_big.sv
// Single-clock 2-port memory: one wide word written per cycle as RATIO narrow
// entries, one narrow entry read per cycle through an output register.
module iob_2p_assim_mem_w_big
  import iob_sync_asym_fifo_w_big_pkg::*;
#(
  parameter int W_DATA_W = 32,
  parameter int R_DATA_W = 8,
  parameter int R_ADDR_W = 6,
  localparam int RATIO    = calc_ratio(W_DATA_W, R_DATA_W),
  localparam int W_ADDR_W = calc_w_addr_w(R_ADDR_W, RATIO)
) (
  input  logic                clk,
  input  logic                w_en,
  input  logic [W_ADDR_W-1:0] w_addr,
  input  logic [W_DATA_W-1:0] w_data,
  input  logic                r_en,
  input  logic [R_ADDR_W-1:0] r_addr,
  output logic [R_DATA_W-1:0] r_data
);

  localparam int SEL_W = max_i(1, R_ADDR_W - W_ADDR_W);
  localparam int DEPTH = 2 ** R_ADDR_W;

  logic [R_DATA_W-1:0] mem_q [DEPTH];
  logic [R_DATA_W-1:0] w_slice [RATIO];
  logic [R_DATA_W-1:0] r_data_q, r_data_d;

  // Slice k of the wide word lands at narrow address {w_addr, k}.
  for (genvar gi = 0; gi < RATIO; gi++) begin : g_slice
    assign w_slice[gi] = w_data[(gi+1)*R_DATA_W-1 -: R_DATA_W];
  end

  always_comb begin
    r_data_d = r_data_q;
    if (r_en) r_data_d = mem_q[r_addr];
  end

  always_ff @(posedge clk) begin
    if (w_en) begin
      for (int k = 0; k < RATIO; k++) begin
        mem_q[{w_addr, SEL_W'(k)}] <= w_slice[k];
      end
    end
    r_data_q <= r_data_d;
  end

  assign r_data = r_data_q;

endmodule

// File: rtl/iob_sync_asym_fifo_w_big.sv
// Synchronous FIFO with a wide push port and a narrow pop port; wide words are
// drained least-significant slice first with one cycle of read latency.
module iob_sync_asym_fifo_w_big
  import iob_sync_asym_fifo_w_big_pkg::*;
#(
  parameter int W_DATA_W = 32,
  parameter int R_DATA_W = 8,
  parameter int R_ADDR_W = 6,
  localparam int RATIO    = calc_ratio(W_DATA_W, R_DATA_W),
  localparam int W_ADDR_W = calc_w_addr_w(R_ADDR_W, RATIO)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                w_en,
  input  logic [W_DATA_W-1:0] w_data,
  output logic                full,
  input  logic                r_en,
  output logic [R_DATA_W-1:0] r_data,
  output logic                empty,
  output logic [R_ADDR_W:0]   level
);

  localparam int DEPTH = 2 ** R_ADDR_W;
  localparam logic [R_ADDR_W:0] RATIO_L = (R_ADDR_W+1)'(RATIO);
  localparam logic [R_ADDR_W:0] ONE_L   = (R_ADDR_W+1)'(1);
  localparam logic [R_ADDR_W:0] FULL_TH = (R_ADDR_W+1)'(DEPTH - RATIO);

  if (!params_ok(W_DATA_W, R_DATA_W, R_ADDR_W)) begin : g_bad_params
    $error("iob_sync_asym_fifo_w_big: illegal W_DATA_W/R_DATA_W/R_ADDR_W");
  end

  logic [W_ADDR_W-1:0] w_ptr_q, w_ptr_d;
  logic [R_ADDR_W-1:0] r_ptr_q, r_ptr_d;
  logic [R_ADDR_W:0]   level_q, level_d;
  logic                rd_seen_q, rd_seen_d;
  logic                w_acc, r_acc;
  logic [R_DATA_W-1:0] mem_r_data;

  // Full means less than one whole wide slot is free, so a partially drained
  // slot keeps blocking writes until all of its slices are gone.
  assign empty = (level_q == '0);
  assign full  = (level_q > FULL_TH);
  assign level = level_q;

  assign w_acc = w_en & ~full;
  assign r_acc = r_en & ~empty;

  always_comb begin
    w_ptr_d   = w_ptr_q;
    r_ptr_d   = r_ptr_q;
    level_d   = level_q;
    rd_seen_d = rd_seen_q | r_acc;
    if (w_acc) w_ptr_d = w_ptr_q + 1'b1;
    if (r_acc) r_ptr_d = r_ptr_q + 1'b1;
    case ({w_acc, r_acc})
      2'b10:   level_d = level_q + RATIO_L;
      2'b01:   level_d = level_q - ONE_L;
      2'b11:   level_d = level_q + RATIO_L - ONE_L;
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      w_ptr_q   <= '0;
      r_ptr_q   <= '0;
      level_q   <= '0;
      rd_seen_q <= 1'b0;
    end else begin
      w_ptr_q   <= w_ptr_d;
      r_ptr_q   <= r_ptr_d;
      level_q   <= level_d;
      rd_seen_q <= rd_seen_d;
    end
  end

  iob_2p_assim_mem_w_big #(
    .W_DATA_W (W_DATA_W),
    .R_DATA_W (R_DATA_W),
    .R_ADDR_W (R_ADDR_W)
  ) u_mem (
    .clk    (clk),
    .w_en   (w_acc & rst_n),
    .w_addr (w_ptr_q),
    .w_data (w_data),
    .r_en   (r_acc & rst_n),
    .r_addr (r_ptr_q),
    .r_data (mem_r_data)
  );

  // The memory's read register is not reset; hide its stale contents until
  // the first accepted read after reset refreshes it.
  assign r_data = rd_seen_q ? mem_r_data : '0;

endmodule

// File: tb/tb_iob_sync_asym_fifo_w_big.sv
// Directed scoreboard bench for the asymmetric FIFO: stimulus queues expected
// narrow words, a monitor compares them one cycle after each issued read.
module tb_iob_sync_asym_fifo_w_big;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        w_en;
  logic [31:0] w_data;
  logic        full;
  logic        r_en;
  logic [7:0]  r_data;
  logic        empty;
  logic [6:0]  level;

  logic        rd_expect;
  logic [7:0]  exp_q[$];
  int          n_cmp = 0;
  int          n_bad = 0;

  always #5 clk = ~clk;

  iob_sync_asym_fifo_w_big dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .w_en   (w_en),
    .w_data (w_data),
    .full   (full),
    .r_en   (r_en),
    .r_data (r_data),
    .empty  (empty),
    .level  (level)
  );

  function automatic void chk(input string name, input logic [31:0] act,
                              input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic logic [7:0] sl(input int i, input int k);
    return 8'(4 * i + k);
  endfunction

  function automatic logic [31:0] wword(input int i);
    return {sl(i, 3), sl(i, 2), sl(i, 1), sl(i, 0)};
  endfunction

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic push(input logic [31:0] w);
    w_en   = 1'b1;
    w_data = w;
    tick();
    w_en   = 1'b0;
    $display("wr  w_data=%h level=%0d", w, level);
  endtask

  task automatic pop(input logic [7:0] e);
    r_en      = 1'b1;
    rd_expect = 1'b1;
    exp_q.push_back(e);
    tick();
    r_en      = 1'b0;
    rd_expect = 1'b0;
  endtask

  // Monitor: a read issued at a rising edge is checked at the next falling edge.
  initial begin
    logic       seen;
    logic [7:0] e;
    forever begin
      @(posedge clk);
      seen = rd_expect;
      @(negedge clk);
      if (seen) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL rd_unexpected: got %h want none", r_data);
        end else begin
          e = exp_q.pop_front();
          chk("r_data", {24'b0, r_data}, {24'b0, e});
          $display("rd  r_data=%h exp=%h level=%0d", r_data, e, level);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n     = 1'b0;
    w_en      = 1'b1;
    r_en      = 1'b1;
    w_data    = 32'hDEADBEEF;
    rd_expect = 1'b0;
    repeat (3) tick();
    chk("rst_level", level, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_r_data", r_data, 0);
    rst_n = 1'b1;
    w_en  = 1'b0;
    r_en  = 1'b0;
    tick();
    chk("post_rst_level", level, 0);

    // Ordering: LSB slice first, level steps down by one per pop.
    push(32'h44332211);
    chk("ord_level4", level, 4);
    pop(8'h11); chk("ord_level3", level, 3);
    pop(8'h22); chk("ord_level2", level, 2);
    pop(8'h33); chk("ord_level1", level, 1);
    pop(8'h44); chk("ord_level0", level, 0);
    chk("ord_empty", empty, 1);

    // Fill to capacity, then a rejected push.
    for (int i = 0; i < 16; i++) push(wword(i));
    chk("fill_level", level, 64);
    chk("fill_full", full, 1);
    push(32'hFFFFFFFF);
    chk("fill_17th_level", level, 64);

    // Full threshold with a partially drained slot.
    pop(sl(0, 0));
    chk("th_level63", level, 63);
    chk("th_full63", full, 1);
    for (int k = 1; k < 4; k++) pop(sl(0, k));
    chk("th_level60", level, 60);
    chk("th_full60", full, 0);
    push(32'h43424140);
    chk("th_refill_level", level, 64);
    for (int i = 1; i < 16; i++)
      for (int k = 0; k < 4; k++) pop(sl(i, k));
    for (int k = 0; k < 4; k++) pop(8'(8'h40 + k));
    chk("drain_level", level, 0);
    chk("drain_empty", empty, 1);

    // Concurrent read+write at level 8, then at empty.
    push(32'hA3A2A1A0);
    push(32'hA7A6A5A4);
    chk("conc_level8", level, 8);
    w_en = 1'b1; w_data = 32'hABAAA9A8;
    r_en = 1'b1; rd_expect = 1'b1; exp_q.push_back(8'hA0);
    tick();
    w_en = 1'b0; r_en = 1'b0; rd_expect = 1'b0;
    chk("conc_level11", level, 11);
    for (int k = 1; k < 12; k++) pop(8'(8'hA0 + k));
    chk("conc_empty", empty, 1);
    w_en = 1'b1; w_data = 32'hB3B2B1B0; r_en = 1'b1;
    tick();
    w_en = 1'b0; r_en = 1'b0;
    chk("conc_empty_level", level, 4);
    chk("conc_empty_hold", r_data, 8'hAB);
    for (int k = 0; k < 4; k++) pop(8'(8'hB0 + k));

    // Streaming 40 words with overlapped push/pop; both pointers wrap.
    push(wword(0));
    for (int i = 1; i < 40; i++) begin
      w_en = 1'b1; w_data = wword(i);
      r_en = 1'b1; rd_expect = 1'b1; exp_q.push_back(sl(i - 1, 0));
      tick();
      w_en = 1'b0; r_en = 1'b0; rd_expect = 1'b0;
      for (int k = 1; k < 4; k++) pop(sl(i - 1, k));
      chk("stream_level", level, 4);
    end
    for (int k = 0; k < 4; k++) pop(sl(39, k));
    chk("stream_empty", empty, 1);

    // Reset in the middle of operation.
    for (int i = 0; i < 5; i++) push(32'h12345678);
    chk("mid_level20", level, 20);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("mid_rst_level", level, 0);
    chk("mid_rst_empty", empty, 1);
    chk("mid_rst_r_data", r_data, 0);
    push(32'hDDCCBBAA);
    pop(8'hAA); pop(8'hBB); pop(8'hCC); pop(8'hDD);
    chk("final_empty", empty, 1);
    tick();
    chk("scoreboard_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
